// File: rtl/bcd_sched_pkg.sv
// Shared types and helpers for the BCD converter scheduler.
package bcd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        CONVERT = 2'b11,
        CAPTURE = 2'b10
    } sched_state_t;

    // Shortest watchdog that still covers a full shift/add-3 conversion.
    function automatic int min_timeout(input int dw);
        return 2 * dw + 2;
    endfunction

endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin picker: searches from pointer+1 upward, wrapping.
module rr_arbiter #(
    parameter int N_CH  = 3,
    parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    int cand;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = 0;
        for (int i = N_CH; i >= 1; i--) begin
            cand = (int'(pointer) + i) % N_CH;
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                index       = IDX_W'(cand);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shares one iterative binary-to-BCD converter among N_CH requesters with a watchdog.
// Define BCD_SCHED_SIGNED_EN for two's-complement channel data (sign/magnitude split).
module bcd_conv_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int DATA_WIDTH  = 12,
    parameter int BCD_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_CH-1:0]              req,
    input  logic [N_CH*DATA_WIDTH-1:0]   ch_data,
    output logic [N_CH-1:0]              ack,
    output logic [N_CH*BCD_DIGITS*4-1:0] ch_bcd,
    output logic [N_CH-1:0]              ch_neg,
    output logic [N_CH-1:0]              ch_valid,
    output logic                         busy,
    output logic                         timeout,
    output logic                         conv_enable,
    output logic [DATA_WIDTH-1:0]        conv_bin,
    input  logic [BCD_DIGITS*4-1:0]      conv_bcd,
    input  logic                         conv_ready
);

    localparam int BCD_W  = BCD_DIGITS * 4;
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TO_EFF = (TIMEOUT_CYC < min_timeout(DATA_WIDTH)) ?
                            min_timeout(DATA_WIDTH) : TIMEOUT_CYC;
    localparam int WD_W   = $clog2(TO_EFF);

    sched_state_t          state_reg;
    logic [IDX_W-1:0]      ptr_reg;
    logic [N_CH-1:0]       gnt_reg;
    logic [DATA_WIDTH-1:0] operand_reg;
    logic                  sign_reg;
    logic [WD_W-1:0]       wd_reg;
    logic [BCD_W-1:0]      bcd_reg [N_CH];
    logic [N_CH-1:0]       neg_reg;
    logic [N_CH-1:0]       valid_reg;
    logic [N_CH-1:0]       ack_reg;
    logic                  timeout_reg;

    logic [N_CH-1:0]       arb_grant;
    logic [IDX_W-1:0]      arb_index;
    logic                  arb_any;
    logic [DATA_WIDTH-1:0] ch_word [N_CH];
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] grant_mag;
    logic                  grant_neg;

    rr_arbiter #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .pointer (ptr_reg),
        .grant   (arb_grant),
        .index   (arb_index),
        .any     (arb_any)
    );

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign ch_word[gi]                 = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign ch_bcd[gi*BCD_W +: BCD_W]   = bcd_reg[gi];
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_reg[i]) sel_data = ch_word[i];
        end
    end

`ifdef BCD_SCHED_SIGNED_EN
    // Negating the most-negative value wraps back to 2^(DATA_WIDTH-1), which is its true magnitude.
    assign grant_mag = sel_data[DATA_WIDTH-1] ? (~sel_data + DATA_WIDTH'(1)) : sel_data;
    assign grant_neg = sel_data[DATA_WIDTH-1] && (grant_mag != '0);
`else
    assign grant_mag = sel_data;
    assign grant_neg = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= IDX_W'(N_CH - 1);
            gnt_reg     <= '0;
            operand_reg <= '0;
            sign_reg    <= 1'b0;
            wd_reg      <= '0;
            neg_reg     <= '0;
            valid_reg   <= '0;
            ack_reg     <= '0;
            timeout_reg <= 1'b0;
            for (int i = 0; i < N_CH; i++) bcd_reg[i] <= '0;
        end else begin
            ack_reg     <= '0;
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        ptr_reg   <= arb_index;
                        gnt_reg   <= arb_grant;
                        state_reg <= GRANT;
                    end
                end
                GRANT: begin
                    operand_reg <= grant_mag;
                    sign_reg    <= grant_neg;
                    wd_reg      <= '0;
                    state_reg   <= CONVERT;
                end
                CONVERT: begin
                    // The converter clears its result on the next edge, so capture it now.
                    if (conv_ready) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (gnt_reg[i]) begin
                                bcd_reg[i]   <= conv_bcd;
                                valid_reg[i] <= 1'b1;
                                neg_reg[i]   <= sign_reg;
                            end
                        end
                        ack_reg   <= gnt_reg;
                        state_reg <= CAPTURE;
                    end else if (wd_reg == WD_W'(TO_EFF - 1)) begin
                        valid_reg   <= valid_reg & ~gnt_reg;
                        ack_reg     <= gnt_reg;
                        timeout_reg <= 1'b1;
                        state_reg   <= CAPTURE;
                    end else begin
                        wd_reg <= wd_reg + WD_W'(1);
                    end
                end
                CAPTURE: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ack         = ack_reg;
    assign ch_neg      = neg_reg;
    assign ch_valid    = valid_reg;
    assign timeout     = timeout_reg;
    assign busy        = (state_reg != IDLE);
    assign conv_enable = (state_reg == CONVERT);
    assign conv_bin    = operand_reg;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler with a behavioural converter that can be forced to hang.
module tb_bcd_conv_scheduler;

    localparam int N_CH  = 3;
    localparam int DW    = 12;
    localparam int BD    = 4;
    localparam int LIMIT = 200;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N_CH-1:0]   req = '0;
    logic [N_CH*DW-1:0] ch_data = '0;
    logic [N_CH-1:0]   ack;
    logic [N_CH*BD*4-1:0] ch_bcd;
    logic [N_CH-1:0]   ch_neg;
    logic [N_CH-1:0]   ch_valid;
    logic              busy;
    logic              timeout;
    logic              conv_enable;
    logic [DW-1:0]     conv_bin;
    logic [BD*4-1:0]   conv_bcd;
    logic              conv_ready;

    logic              stub_hang = 1'b0;
    int                conv_cnt;
    int                errors = 0;
    int                checks = 0;
    int                n;

    always #5 clk = ~clk;

    bcd_conv_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .ch_data     (ch_data),
        .ack         (ack),
        .ch_bcd      (ch_bcd),
        .ch_neg      (ch_neg),
        .ch_valid    (ch_valid),
        .busy        (busy),
        .timeout     (timeout),
        .conv_enable (conv_enable),
        .conv_bin    (conv_bin),
        .conv_bcd    (conv_bcd),
        .conv_ready  (conv_ready)
    );

    function automatic logic [15:0] to_bcd(input logic [DW-1:0] b);
        int v;
        v = int'(b);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Converter: ready on the 26th enabled cycle, result present only while ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         conv_cnt <= 0;
        else if (conv_enable) conv_cnt <= conv_cnt + 1;
        else                  conv_cnt <= 0;
    end
    assign conv_ready = conv_enable && !stub_hang && (conv_cnt == 2 * DW + 1);
    assign conv_bcd   = conv_ready ? to_bcd(conv_bin) : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (ack == '0 && cnt < LIMIT);
        check("ack_seen", 32'(ack != '0), 32'd1);
        $display("ack=%b after %0d cycles bcd=%h neg=%b valid=%b timeout=%b",
                 ack, cnt, ch_bcd, ch_neg, ch_valid, timeout);
    endtask

    function automatic logic [15:0] bcd_of(input int ch);
        return ch_bcd[ch*16 +: 16];
    endfunction

    task automatic set_data(input int ch, input logic [DW-1:0] d);
        ch_data[ch*DW +: DW] = d;
    endtask

    // One isolated conversion on a single channel from IDLE.
    task automatic single(input string tag, input int ch, input logic [DW-1:0] d,
                          input logic [15:0] exp_bcd, input logic exp_neg);
        set_data(ch, d);
        req = N_CH'(1) << ch;
        wait_ack(n);
        req = '0;
        check({tag, "_lat"},   32'(n), 32'd28);
        check({tag, "_ack"},   32'(ack), 32'(N_CH'(1) << ch));
        check({tag, "_bcd"},   32'(bcd_of(ch)), 32'(exp_bcd));
        check({tag, "_neg"},   32'(ch_neg[ch]), 32'(exp_neg));
        check({tag, "_valid"}, 32'(ch_valid[ch]), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #23;
        check("rst_ack",   32'(ack), 32'd0);
        check("rst_bcd",   32'(ch_bcd), 32'd0);
        check("rst_valid", 32'(ch_valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_en",    32'(conv_enable), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        single("ch0_7ff", 0, 12'h7FF, 16'h2047, 1'b0);
        check("ch0_timeout", 32'(timeout), 32'd0);
`ifdef BCD_SCHED_SIGNED_EN
        single("ch1_b2e", 1, 12'hB2E, 16'h1234, 1'b1);
        single("ch1_800", 1, 12'h800, 16'h2048, 1'b1);
`else
        single("ch1_b2e", 1, 12'hB2E, 16'h2862, 1'b0);
        single("ch1_800", 1, 12'h800, 16'h2048, 1'b0);
`endif
        single("ch2_zero", 2, 12'h000, 16'h0000, 1'b0);

        // All three held: rotation ch0, ch1, ch2, ch0.
        set_data(0, 12'd1);
        set_data(1, 12'd2);
        set_data(2, 12'h3E7);
        req = 3'b111;
        wait_ack(n);
        check("rr0_lat", 32'(n), 32'd28);
        check("rr0_ack", 32'(ack), 32'b001);
        check("rr0_en",  32'(conv_enable), 32'd0);
        wait_ack(n);
        check("rr1_gap", 32'(n), 32'd29);
        check("rr1_ack", 32'(ack), 32'b010);
        check("rr1_en",  32'(conv_enable), 32'd0);
        wait_ack(n);
        check("rr2_gap", 32'(n), 32'd29);
        check("rr2_ack", 32'(ack), 32'b100);
        wait_ack(n);
        req = '0;
        check("rr3_gap", 32'(n), 32'd29);
        check("rr3_ack", 32'(ack), 32'b001);
        check("rr_bcd0", 32'(bcd_of(0)), 32'h0001);
        check("rr_bcd1", 32'(bcd_of(1)), 32'h0002);
        check("rr_bcd2", 32'(bcd_of(2)), 32'h0999);
        @(negedge clk);

        // Hung converter on ch1 while ch0 also waits; ch1 is next in turn.
        set_data(0, 12'h7FF);
        stub_hang = 1'b1;
        req = 3'b011;
        wait_ack(n);
        req = 3'b001;
        stub_hang = 1'b0;
        check("to_lat",     32'(n), 32'd66);
        check("to_ack",     32'(ack), 32'b010);
        check("to_pulse",   32'(timeout), 32'd1);
        check("to_valid1",  32'(ch_valid[1]), 32'd0);
        check("to_bcd1",    32'(bcd_of(1)), 32'h0002);
        check("to_en",      32'(conv_enable), 32'd0);
        @(negedge clk);
        check("to_pulse_end", 32'(timeout), 32'd0);
        wait_ack(n);
        req = '0;
        check("after_to_lat", 32'(n), 32'd28);
        check("after_to_ack", 32'(ack), 32'b001);
        check("after_to_bcd", 32'(bcd_of(0)), 32'h2047);
        @(negedge clk);

        // Reset in the middle of a conversion.
        set_data(2, 12'h123);
        req = 3'b100;
        repeat (10) @(negedge clk);
        check("pre_rst_en", 32'(conv_enable), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_en",    32'(conv_enable), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_bcd",   32'(ch_bcd), 32'd0);
        check("mid_rst_valid", 32'(ch_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_data(0, 12'd42);
        req = 3'b101;
        wait_ack(n);
        req = '0;
        check("post_rst_lat",   32'(n), 32'd28);
        check("post_rst_ack",   32'(ack), 32'b001);
        check("post_rst_bcd",   32'(bcd_of(0)), 32'h0042);
        check("post_rst_valid", 32'(ch_valid), 32'b001);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
